// File: rtl/fsm_mon_pkg.sv
// Shared definitions for the control-FSM state-code monitor: code values, monitor state
// encoding, violation kinds and the legal-transition graph.
package fsm_mon_pkg;

  localparam logic [1:0] CODE_S0 = 2'b00;
  localparam logic [1:0] CODE_S1 = 2'b01;
  localparam logic [1:0] CODE_S2 = 2'b10;
  localparam logic [1:0] CODE_S3 = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StTrack = 2'b01,
    StAlarm = 2'b10
  } mon_state_e;

  localparam logic [1:0] VK_NONE    = 2'b00;
  localparam logic [1:0] VK_ILLEGAL = 2'b01;
  localparam logic [1:0] VK_DWELL   = 2'b10;

  // Self-loops are always legal; code 01 is terminal.
  function automatic logic legal_trans(input logic [1:0] prev, input logic [1:0] cur);
    logic ok;
    ok = 1'b0;
    if (prev == cur) begin
      ok = 1'b1;
    end else begin
      case ({prev, cur})
        {CODE_S0, CODE_S1},
        {CODE_S0, CODE_S2},
        {CODE_S2, CODE_S1},
        {CODE_S2, CODE_S3},
        {CODE_S3, CODE_S2}: ok = 1'b1;
        default:            ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/fsm_mon_dwell_ctr.sv
// Saturating dwell counter; expire pulses once, on the step that brings the count to
// DWELL_MAX, and stays quiet until a restart begins a new episode.
module fsm_mon_dwell_ctr #(
  parameter int unsigned DWELL_MAX = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic step,
  input  logic restart,
  output logic expire
);

  localparam int unsigned W = $clog2(DWELL_MAX + 1);
  localparam logic [W-1:0] CntMax = W'(DWELL_MAX);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    expire = 1'b0;
    if (step) begin
      if (restart) begin
        cnt_d = W'(1);
      end else if (cnt_q != CntMax) begin
        cnt_d  = cnt_q + W'(1);
        expire = (cnt_d == CntMax);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fsm_code_monitor.sv
// Security monitor for the 2-bit control-FSM state code: flags illegal transitions and
// over-long dwell. Define FSM_MON_LOCK_EN to make ALARM a lockdown only rst can leave.
module fsm_code_monitor
  import fsm_mon_pkg::*;
#(
  parameter int unsigned DWELL_MAX  = 16,
  parameter logic [3:0]  DWELL_MASK = 4'b1100,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       code_in,
  input  logic             clr_alarm,
  output logic             alarm,
  output logic [1:0]       viol_kind,
  output logic [1:0]       viol_prev,
  output logic [1:0]       viol_cur,
  output logic [CNT_W-1:0] viol_cnt,
  output logic             mon_busy
);

`ifdef FSM_MON_LOCK_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif

  mon_state_e state_q, state_d;
  logic [1:0] last_q;
  logic       in_idle, in_alarm, sample, illegal, expire, viol, clr_eff, restart;

  assign in_idle  = (state_q == StIdle);
  assign in_alarm = (state_q == StAlarm);
  assign sample   = en && !(LockEn && in_alarm);
  assign clr_eff  = clr_alarm && in_alarm && !LockEn;

  // The reference sample is checked against the post-reset code 00.
  assign illegal = in_idle ? (code_in != CODE_S0) : !legal_trans(last_q, code_in);
  assign restart = in_idle || (code_in != last_q) || !DWELL_MASK[code_in];
  assign viol    = sample && (illegal || expire);

  fsm_mon_dwell_ctr #(
    .DWELL_MAX(DWELL_MAX)
  ) u_dwell (
    .clk    (clk),
    .rst    (rst),
    .step   (sample),
    .restart(restart),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (sample) state_d = viol ? StAlarm : StTrack;
      StTrack: if (viol) state_d = StAlarm;
      StAlarm: if (clr_eff && !viol) state_d = StTrack;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mon_busy = (state_q != StIdle);
  end

  // Capture holds the first violation unless a clear coincides with a new one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q    <= CODE_S0;
      alarm     <= 1'b0;
      viol_kind <= VK_NONE;
      viol_prev <= CODE_S0;
      viol_cur  <= CODE_S0;
      viol_cnt  <= '0;
    end else begin
      if (sample) begin
        last_q <= code_in;
      end
      if (viol) begin
        if (viol_cnt != '1) begin
          viol_cnt <= viol_cnt + CNT_W'(1);
        end
        if (!in_alarm || clr_eff) begin
          alarm     <= 1'b1;
          viol_kind <= illegal ? VK_ILLEGAL : VK_DWELL;
          viol_prev <= in_idle ? CODE_S0 : last_q;
          viol_cur  <= code_in;
        end
      end else if (clr_eff) begin
        alarm     <= 1'b0;
        viol_kind <= VK_NONE;
        viol_prev <= CODE_S0;
        viol_cur  <= CODE_S0;
      end
    end
  end

endmodule

// File: tb/tb_fsm_code_monitor.sv
// Table-driven bench for fsm_code_monitor (DWELL_MAX=4, CNT_W=2) with a scoreboard queue
// of expected outputs; the table switches when FSM_MON_LOCK_EN is defined.
module tb_fsm_code_monitor;

  typedef struct {
    bit         rst_first;
    logic       en;
    logic [1:0] code;
    logic       clr;
    logic [9:0] exp_out;  // {alarm, kind, prev, cur, cnt, busy}
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [1:0] code_in = 2'b00;
  logic       clr_alarm = 1'b0;
  logic       alarm, mon_busy;
  logic [1:0] viol_kind, viol_prev, viol_cur, viol_cnt;

  int n_total = 0;
  int n_pass  = 0;
  vec_t       vecs[$];
  logic [9:0] exp_q[$];

  fsm_code_monitor #(
    .DWELL_MAX (4),
    .DWELL_MASK(4'b1100),
    .CNT_W     (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .code_in  (code_in),
    .clr_alarm(clr_alarm),
    .alarm    (alarm),
    .viol_kind(viol_kind),
    .viol_prev(viol_prev),
    .viol_cur (viol_cur),
    .viol_cnt (viol_cnt),
    .mon_busy (mon_busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(bit r, logic e, logic [1:0] c, logic cl, logic a, logic [1:0] k,
                              logic [1:0] p, logic [1:0] cu, logic [1:0] n, logic b);
    vec_t v;
    v.rst_first = r;
    v.en        = e;
    v.code      = c;
    v.clr       = cl;
    v.exp_out   = {a, k, p, cu, n, b};
    return v;
  endfunction

  task automatic check(input string name, input logic [9:0] want);
    logic [9:0] got;
    got = {alarm, viol_kind, viol_prev, viol_cur, viol_cnt, mon_busy};
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got {alarm,kind,prev,cur,cnt,busy}=%b required %b", name, got, want);
  endtask

  // Asserted mid-cycle: outputs must clear without a clock edge.
  task automatic do_reset(input string name);
    rst = 1'b1;
    #2;
    check(name, 10'b0);
    rst = 1'b0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    en        = v.en;
    code_in   = v.code;
    clr_alarm = v.clr;
    exp_q.push_back(v.exp_out);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL vec%0d: scoreboard empty", idx);
    end else begin
      check($sformatf("vec%0d", idx), exp_q.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // Legal walk 00,00,10,11,10,01: no alarm.
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 2, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 2, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 1));
    // en=0 in IDLE, then a non-00 reference is a violation.
    vecs.push_back(mk(1, 0, 3, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 2, 0, 1, 1, 0, 2, 1, 1));
`ifdef FSM_MON_LOCK_EN
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 0, 2, 1, 1));
    // 00->11 illegal; lockdown ignores clr and further samples.
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 3, 0, 1, 1, 0, 3, 1, 1));
    vecs.push_back(mk(0, 0, 3, 1, 1, 1, 0, 3, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 0, 3, 1, 1));
    vecs.push_back(mk(0, 1, 3, 1, 1, 1, 0, 3, 1, 1));
    vecs.push_back(mk(0, 1, 0, 1, 1, 1, 0, 3, 1, 1));
    // Dwell timeout then frozen.
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 2, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 2, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 2, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 2, 0, 1, 2, 2, 2, 1, 1));
    vecs.push_back(mk(0, 1, 1, 0, 1, 2, 2, 2, 1, 1));
    vecs.push_back(mk(0, 1, 0, 1, 1, 2, 2, 2, 1, 1));
`else
    vecs.push_back(mk(0, 1, 3, 0, 1, 1, 0, 2, 1, 1));
    // 00->11 illegal, en=0 holds, clr clears but keeps count, clr outside ALARM ignored.
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 3, 0, 1, 1, 0, 3, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 1, 1, 0, 3, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 2, 1, 0, 0, 0, 0, 1, 1));
    // Dwell: 4th consecutive 10 fires once; then clr+illegal 01->00 (violation wins).
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 2, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 2, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 2, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 2, 0, 1, 2, 2, 2, 1, 1));
    vecs.push_back(mk(0, 1, 2, 0, 1, 2, 2, 2, 1, 1));
    vecs.push_back(mk(0, 1, 2, 0, 1, 2, 2, 2, 1, 1));
    vecs.push_back(mk(0, 1, 1, 0, 1, 2, 2, 2, 1, 1));
    vecs.push_back(mk(0, 1, 0, 1, 1, 1, 1, 0, 2, 1));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 2, 1));
    // More illegal hops: count saturates at 3, capture keeps the first.
    vecs.push_back(mk(0, 1, 3, 0, 1, 1, 0, 3, 3, 1));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 0, 3, 3, 1));
    vecs.push_back(mk(0, 1, 3, 0, 1, 1, 0, 3, 3, 1));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 0, 3, 3, 1));
`endif

    #1;
    foreach (vecs[i]) begin
      if (vecs[i].rst_first) do_reset($sformatf("reset_before_vec%0d", i));
      apply(vecs[i], i);
    end

    // Async reset mid-cycle from an alarmed state, then a fresh reference.
    en      = 1'b1;
    code_in = 2'b01;
    do_reset("async_reset_mid_cycle");
    apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1), 1000);
    apply(mk(0, 1, 3, 0, 1, 1, 0, 3, 1, 1), 1001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
